pipe_cla_subtractor: RTL

- Pipelined, width-scalable subtractor computing diff = a - b - bin, with borrow-out and signed-overflow flags.
- Complements the team's 4-bit carry-lookahead adder: it reuses that adder as its per-slice engine via a + ~b + ~bin.
- Each 4-bit slice is one pipeline stage, and the borrow is registered between stages.
- Sits between operand producers and consumers on a valid/ready stream, and supports full backpressure.

---
 rtl/sub_pkg.sv | 17 +
 rtl/cla.sv | 28 ++
 rtl/pipe_cla_subtractor.sv | 127 ++++++++++++
 3 files changed

// File: rtl/sub_pkg.sv
// Shared definitions for the pipelined carry-lookahead subtractor and its consumers.
package sub_pkg;

    localparam int SLICE_W = 4;
    localparam int RES_W   = 16;

    function automatic int nstage(input int width);
        return width / SLICE_W;
    endfunction

    typedef struct packed {
        logic [RES_W-1:0] diff;
        logic             bout;
        logic             ovf;
    } sub_res_t;

endpackage

// File: rtl/cla.sv
// 4-bit carry-lookahead adder: sum = a + b + cin, purely combinational.
module cla (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is flattened from cin so no ripple path exists inside the slice.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum  = p ^ c[3:0];
    assign cout = c[4];

endmodule

// File: rtl/pipe_cla_subtractor.sv
// Pipelined a - b - bin, one 4-bit slice per stage; latency WIDTH/4 cycles, 1 beat/cycle.
// Valid/ready stream with full backpressure: a stage loads only when it advances, bubbles collapse.
module pipe_cla_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int NSTAGE = nstage(WIDTH);

    if (WIDTH < SLICE_W || (WIDTH % SLICE_W) != 0) begin : g_bad_width
        $error("pipe_cla_subtractor: WIDTH must be a multiple of 4 and at least 4");
    end

    logic [NSTAGE-1:0] vld;
    logic [NSTAGE:0]   adv;

    always_comb begin
        adv         = '0;
        adv[NSTAGE] = out_ready;
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            adv[k] = ~vld[k] | adv[k+1];
        end
    end

    assign in_ready = adv[0];

    for (genvar k = 0; k < NSTAGE; k++) begin : g_stg
        // SW: operand bits still unconsumed when the beat enters this stage.
        localparam int SW = WIDTH - SLICE_W * k;

        logic [SW-1:0]            src_a;
        logic [SW-1:0]            src_b;
        logic                     src_c;
        logic                     src_v;
        logic [SLICE_W-1:0]       sum;
        logic                     cout;
        logic [SLICE_W*(k+1)-1:0] diff_d;
        logic [SLICE_W*(k+1)-1:0] diff_q;
        logic                     v_q;

        if (k == 0) begin : g_src
            assign src_a  = a;
            assign src_b  = b;
            assign src_c  = ~bin;
            assign src_v  = in_valid;
            assign diff_d = sum;
        end else begin : g_src
            assign src_a  = g_stg[k-1].g_fwd.a_q;
            assign src_b  = g_stg[k-1].g_fwd.b_q;
            assign src_c  = g_stg[k-1].g_fwd.c_q;
            assign src_v  = g_stg[k-1].v_q;
            assign diff_d = {sum, g_stg[k-1].diff_q};
        end

        cla u_cla (
            .a    (src_a[SLICE_W-1:0]),
            .b    (~src_b[SLICE_W-1:0]),
            .cin  (src_c),
            .sum  (sum),
            .cout (cout)
        );

        always_ff @(posedge clk) begin
            if (rst) begin
                v_q    <= 1'b0;
                diff_q <= '0;
            end else if (adv[k]) begin
                v_q    <= src_v;
                diff_q <= diff_d;
            end
        end

        assign vld[k] = v_q;

        if (k < NSTAGE - 1) begin : g_fwd
            logic [SW-SLICE_W-1:0] a_q;
            logic [SW-SLICE_W-1:0] b_q;
            logic                  c_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                    c_q <= 1'b0;
                end else if (adv[k]) begin
                    a_q <= src_a[SW-1:SLICE_W];
                    b_q <= src_b[SW-1:SLICE_W];
                    c_q <= cout;
                end
            end
        end else begin : g_last
            logic bout_q;
            logic ovf_q;

            // Only the top slice sees both operand sign bits and the result sign together.
            always_ff @(posedge clk) begin
                if (rst) begin
                    bout_q <= 1'b0;
                    ovf_q  <= 1'b0;
                end else if (adv[k]) begin
                    bout_q <= ~cout;
                    ovf_q  <= (src_a[SW-1] != src_b[SW-1]) && (sum[SLICE_W-1] != src_a[SW-1]);
                end
            end
        end
    end

    assign out_valid = g_stg[NSTAGE-1].v_q;
    assign diff      = g_stg[NSTAGE-1].diff_q;
    assign bout      = g_stg[NSTAGE-1].g_last.bout_q;
    assign ovf       = g_stg[NSTAGE-1].g_last.ovf_q;

endmodule
